// File: rtl/mem_port_arbiter.sv
// Two-port (CPU / debug) arbiter in front of a single-ported data memory.
// Round-robin between requesters, with an optional bounded debug lock.
module mem_port_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int MAX_LOCK = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_dbg_q, owner_dbg_d;
  logic              last_dbg_q, last_dbg_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              dbg_gnt_q, dbg_gnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              dbg_wins;
  logic              sel_we;

  // Winner: lone requester, else round-robin unless debug still holds the lock.
  always_comb begin
    dbg_wins = dbg_req;
    if (cpu_req && dbg_req) begin
      dbg_wins = last_dbg_q ? (dbg_lock && (lock_cnt_q < LOCK_MAX)) : 1'b1;
    end
    sel_we = dbg_wins ? dbg_we : cpu_we;
  end

  always_comb begin
    state_d      = state_q;
    owner_dbg_d  = owner_dbg_q;
    last_dbg_d   = last_dbg_q;
    lock_cnt_d   = lock_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    rdata_d      = rdata_q;
    cpu_gnt_d    = 1'b0;
    dbg_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          state_d     = ACCESS;
          owner_dbg_d = dbg_wins;
          last_dbg_d  = dbg_wins;
          addr_d      = dbg_wins ? dbg_addr : cpu_addr;
          wdata_d     = dbg_wins ? dbg_wdata : cpu_wdata;
          we_d        = sel_we;
          cpu_gnt_d   = !dbg_wins;
          dbg_gnt_d   = dbg_wins;
          mem_read_d  = !sel_we;
          mem_write_d = sel_we;
          if (!dbg_wins) begin
            lock_cnt_d = '0;
          end else if (cpu_req && (lock_cnt_q != LOCK_MAX)) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d      = RESP;
          rdata_d      = mem_rdata;
          cpu_rvalid_d = !owner_dbg_q;
          dbg_rvalid_d = owner_dbg_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset leaves last owner as debug so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_dbg_q  <= 1'b0;
      last_dbg_q   <= 1'b1;
      lock_cnt_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      rdata_q      <= '0;
      cpu_gnt_q    <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_dbg_q  <= owner_dbg_d;
      last_dbg_q   <= last_dbg_d;
      lock_cnt_q   <= lock_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      rdata_q      <= rdata_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dbg_gnt_q    <= dbg_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign dbg_gnt    = dbg_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign rdata      = rdata_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign cpu_stall  = cpu_req && !(cpu_rvalid_q || (cpu_gnt_q && cpu_we));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a
// transaction-level model of arbitration, latency and memory contents.
module tb_mem_port_arbiter;

  localparam int MAX_LOCK = 3;

  logic       clk;
  logic       rst;
  logic       cpuReq, cpuWe, dbgReq, dbgWe, dbgLock;
  logic [7:0] cpuAddr, cpuWdata, dbgAddr, dbgWdata;
  logic       cpuGnt, cpuRvalid, cpuStall, dbgGnt, dbgRvalid;
  logic [7:0] rdata, memAddr, memWdata, memRdata;
  logic       memRead, memWrite;

  logic [7:0] tbMem [256];
  logic [7:0] refMem [256];

  int checkCount;
  int errorCount;

  // Expected outputs for the current cycle.
  logic       expCpuGnt, expDbgGnt, expRead, expWrite, expCpuRv, expDbgRv;
  logic [7:0] expAddr, expWdata, expRdata;

  // Transaction-level model state.
  bit         lastDbg;
  int         lockCount;
  bit         accessPending;
  int         busy;
  bit         txnDbg, txnWe;
  logic [7:0] txnAddr, txnData;

  logic grantLog[$];

  mem_port_arbiter #(.DATA_W(8), .ADDR_W(8), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_gnt(cpuGnt), .cpu_rvalid(cpuRvalid), .cpu_stall(cpuStall),
    .dbg_req(dbgReq), .dbg_we(dbgWe), .dbg_addr(dbgAddr), .dbg_wdata(dbgWdata),
    .dbg_lock(dbgLock), .dbg_gnt(dbgGnt), .dbg_rvalid(dbgRvalid),
    .rdata(rdata), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_read(memRead), .mem_write(memWrite), .mem_rdata(memRdata)
  );

  assign memRdata = tbMem[memAddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    lastDbg = 1'b1;
    lockCount = 0;
    accessPending = 1'b0;
    busy = 0;
    {expCpuGnt, expDbgGnt, expRead, expWrite, expCpuRv, expDbgRv} = '0;
    expAddr = '0;
    expWdata = '0;
    expRdata = '0;
  endtask

  // Advances the model by one cycle using the inputs currently applied.
  task automatic modelStep();
    bit dbgWins;
    {expCpuGnt, expDbgGnt, expRead, expWrite, expCpuRv, expDbgRv} = '0;
    if (accessPending) begin
      accessPending = 1'b0;
      if (txnWe) begin
        refMem[txnAddr] = txnData;
        busy = 0;
      end else begin
        expRdata = refMem[txnAddr];
        expCpuRv = !txnDbg;
        expDbgRv = txnDbg;
        busy = 1;
      end
    end else if (busy > 0) begin
      busy--;
    end else if (cpuReq || dbgReq) begin
      if (cpuReq && dbgReq) dbgWins = lastDbg ? (dbgLock && lockCount < MAX_LOCK) : 1'b1;
      else dbgWins = dbgReq;
      if (dbgWins) begin
        if (cpuReq && lockCount < MAX_LOCK) lockCount++;
      end else begin
        lockCount = 0;
      end
      lastDbg = dbgWins;
      txnDbg  = dbgWins;
      txnWe   = dbgWins ? dbgWe : cpuWe;
      txnAddr = dbgWins ? dbgAddr : cpuAddr;
      txnData = dbgWins ? dbgWdata : cpuWdata;
      accessPending = 1'b1;
      expCpuGnt = !dbgWins;
      expDbgGnt = dbgWins;
      expRead   = !txnWe;
      expWrite  = txnWe;
      expAddr   = txnAddr;
      expWdata  = txnData;
    end
  endtask

  // One clock cycle: starts and ends on a falling edge.
  task automatic applyStimulus(input logic cR, input logic cW, input logic [7:0] cA, input logic [7:0] cD,
                               input logic dR, input logic dW, input logic [7:0] dA, input logic [7:0] dD,
                               input logic lk);
    logic       doWrite;
    logic [7:0] wAddr, wData;
    cpuReq = cR; cpuWe = cW; cpuAddr = cA; cpuWdata = cD;
    dbgReq = dR; dbgWe = dW; dbgAddr = dA; dbgWdata = dD; dbgLock = lk;
    #1;
    checkOutput("cpuStall", cpuStall, cR && !(expCpuRv || (expCpuGnt && cW)));
    doWrite = memWrite;
    wAddr = memAddr;
    wData = memWdata;
    modelStep();
    @(posedge clk);
    if (doWrite === 1'b1) tbMem[wAddr] = wData;
    #1;
    checkOutput("cpuGnt", cpuGnt, expCpuGnt);
    checkOutput("dbgGnt", dbgGnt, expDbgGnt);
    checkOutput("memRead", memRead, expRead);
    checkOutput("memWrite", memWrite, expWrite);
    checkOutput("cpuRvalid", cpuRvalid, expCpuRv);
    checkOutput("dbgRvalid", dbgRvalid, expDbgRv);
    checkOutput("memAddr", memAddr, expAddr);
    checkOutput("memWdata", memWdata, expWdata);
    checkOutput("rdata", rdata, expRdata);
    if (cpuGnt === 1'b1) grantLog.push_back(1'b0);
    if (dbgGnt === 1'b1) grantLog.push_back(1'b1);
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
  endtask

  // Asserts reset asynchronously, checks the forced values, releases on a falling edge.
  task automatic applyReset();
    rst = 1'b0;
    cpuReq = 0; cpuWe = 0; dbgReq = 0; dbgWe = 0; dbgLock = 0;
    #1;
    checkOutput("rstMemWrite", memWrite, 0);
    checkOutput("rstMemRead", memRead, 0);
    checkOutput("rstGnt", {cpuGnt, dbgGnt}, 0);
    checkOutput("rstRvalid", {cpuRvalid, dbgRvalid}, 0);
    checkOutput("rstRdata", rdata, 0);
    checkOutput("rstMemAddr", memAddr, 0);
    checkOutput("rstMemWdata", memWdata, 0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic expOrder[4];
    checkCount = 0;
    errorCount = 0;
    rst = 1'b0;
    {cpuReq, cpuWe, dbgReq, dbgWe, dbgLock} = '0;
    cpuAddr = '0; cpuWdata = '0; dbgAddr = '0; dbgWdata = '0;
    for (int i = 0; i < 256; i++) begin
      tbMem[i] = 8'($urandom_range(0, 255));
      refMem[i] = tbMem[i];
    end
    tbMem[8'h10] = 8'hA5; refMem[8'h10] = 8'hA5;
    modelReset();
    @(negedge clk);
    applyReset();

    $display("[TB] CPU read of 0x10");
    applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    checkOutput("readData", rdata, 8'hA5);
    idleCycle();

    $display("[TB] DBG write 0x3C to 0x20");
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 0);
    checkOutput("writeMem", tbMem[8'h20], 8'h3C);
    idleCycle();

    $display("[TB] Reset during a write access");
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h55, 0);
    applyReset();
    checkOutput("abortedWrite", tbMem[8'h20], 8'h3C);

    $display("[TB] Tie after reset");
    grantLog.delete();
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 8'h30, 8'h11, 1, 1, 8'h31, 8'h22, 0);
    expOrder = '{1'b0, 1'b1, 1'b0, 1'b1};
    checkOutput("tieCount", grantLog.size(), 4);
    for (int i = 0; i < 4 && i < grantLog.size(); i++) checkOutput("tieOrder", grantLog[i], expOrder[i]);

    $display("[TB] Debug lock");
    applyReset();
    applyStimulus(1, 1, 8'h40, 8'h01, 0, 0, 8'h00, 8'h00, 0);
    idleCycle();
    grantLog.delete();
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 8'h41, 8'h02, 1, 1, 8'h42, 8'h03, 1);
    expOrder = '{1'b1, 1'b1, 1'b1, 1'b0};
    checkOutput("lockCount", grantLog.size(), 4);
    for (int i = 0; i < 4 && i < grantLog.size(); i++) checkOutput("lockOrder", grantLog[i], expOrder[i]);

    $display("[TB] Random traffic");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
                    $urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
                    1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
